// File: rtl/mux4_sched_pkg.sv
// rtl/mux4_sched_pkg.sv - shared state encoding and one-hot decode for mux4_rr_sched
package mux4_sched_pkg;

  // 2'd3 is unreachable; the FSM recovers from it by returning to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_GRANT   = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational 4-way round-robin picker starting at ptr
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;

  // Scan from the farthest offset down to ptr so the nearest request wins last.
  always_comb begin
    idx  = 2'd0;
    any  = |req;
    cand = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + k[1:0];
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin owner scheduler for a shared dual 4:1 selector
module mux4_rr_sched
  import mux4_sched_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CW       = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic [1:0] CH_EN,
  output logic [1:0] A,
  output logic [1:0] nS,
  output logic [3:0] GNT,
  output logic       BUSY
);

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);

  state_e        state_q, state_d;
  logic [1:0]    a_q, a_d;
  logic [1:0]    ns_q, ns_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [3:0]    owner_oh;
  logic [3:0]    others;
  logic [3:0]    pick_req;
  logic [1:0]    pick_ptr;
  logic [1:0]    pick_idx;
  logic          pick_any;

  // In GRANT the picker sees only the waiting sources, searched from owner+1;
  // otherwise it sees all requests searched from ptr.
  always_comb begin
    owner_oh = onehot4(a_q);
    others   = REQ & ~owner_oh;
    if (state_q == ST_GRANT) begin
      pick_req = others;
      pick_ptr = a_q + 2'd1;
    end else begin
      pick_req = REQ;
      pick_ptr = ptr_q;
    end
  end

  rr_pick4 u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state and registered-output logic; strobes are forced high on any A change.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    ns_d    = ns_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        ns_d   = 2'b11;
        gnt_d  = 4'b0000;
        busy_d = 1'b0;
        if (pick_any) begin
          state_d = ST_SETTLE;
          a_d     = pick_idx;
          busy_d  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (REQ[a_q]) begin
          state_d = ST_GRANT;
          gnt_d   = owner_oh;
          ns_d    = ~CH_EN;
          cnt_d   = CW'(1);
        end else begin
          state_d = ST_IDLE;
          ns_d    = 2'b11;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!REQ[a_q] || ((cnt_q >= HOLD_C) && pick_any)) begin
          ptr_d = a_q + 2'd1;
          ns_d  = 2'b11;
          gnt_d = 4'b0000;
          if (pick_any) begin
            state_d = ST_SETTLE;
            a_d     = pick_idx;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          ns_d  = ~CH_EN;
          gnt_d = owner_oh;
          if (cnt_q < HOLD_C) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ns_d    = 2'b11;
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_q     <= 2'b00;
      ns_q    <= 2'b11;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      ns_q    <= ns_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A    = a_q;
  assign nS   = ns_q;
  assign GNT  = gnt_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb/tb_mux4_rr_sched.sv - self-checking bench for mux4_rr_sched
module tb_mux4_rr_sched;

  localparam int HOLD_MAX = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] REQ = 4'b0000;
  logic [1:0] CH_EN = 2'b00;
  logic [1:0] A;
  logic [1:0] nS;
  logic [3:0] GNT;
  logic       BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  mux4_rr_sched #(.HOLD_MAX(HOLD_MAX), .CW(4)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .CH_EN (CH_EN),
    .A     (A),
    .nS    (nS),
    .GNT   (GNT),
    .BUSY  (BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference model: phase 0 idle, 1 settle, 2 grant; owner index and hold length as ints.
  int         m_phase = 0;
  int         m_a     = 0;
  int         m_ptr   = 0;
  int         m_held  = 0;
  logic [3:0] m_others;
  logic [1:0] exp_a    = 2'b00;
  logic [1:0] exp_ns   = 2'b11;
  logic [3:0] exp_gnt  = 4'b0000;
  logic       exp_busy = 1'b0;

  function automatic int rr_winner(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase = 0; m_a = 0; m_ptr = 0; m_held = 0;
    end else begin
      m_others = REQ & ~(4'b0001 << m_a);
      if (m_phase == 0) begin
        if (REQ != 4'b0000) begin
          m_a = rr_winner(REQ, m_ptr);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (REQ[m_a]) begin m_phase = 2; m_held = 1; end
        else m_phase = 0;
      end else begin
        if (!REQ[m_a] || (m_held >= HOLD_MAX && m_others != 4'b0000)) begin
          m_ptr = (m_a + 1) % 4;
          if (m_others != 4'b0000) begin
            m_a = rr_winner(m_others, m_ptr);
            m_phase = 1;
          end else begin
            m_phase = 0;
          end
        end else if (m_held < HOLD_MAX) begin
          m_held = m_held + 1;
        end
      end
    end
    exp_a    = 2'(m_a);
    exp_ns   = (m_phase == 2) ? ~CH_EN : 2'b11;
    exp_gnt  = (m_phase == 2) ? (4'b0001 << m_a) : 4'b0000;
    exp_busy = (m_phase != 0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      REQ = 4'($urandom); CH_EN = 2'($urandom);
      tick();
    end
    REQ = 4'($urandom); CH_EN = 2'($urandom);
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({A, nS, GNT, BUSY} !== {2'b00, 2'b11, 4'b0000, 1'b0})
      $display("FAIL reset_async got A=%b nS=%b GNT=%b BUSY=%b exp A=00 nS=11 GNT=0000 BUSY=0", A, nS, GNT, BUSY);
    else n_pass++;
    tick();
    n_checks++;
    if ({A, nS, GNT, BUSY} !== {2'b00, 2'b11, 4'b0000, 1'b0})
      $display("FAIL reset_held got A=%b nS=%b GNT=%b BUSY=%b exp A=00 nS=11 GNT=0000 BUSY=0", A, nS, GNT, BUSY);
    else n_pass++;
    RST = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    REQ = 4'b0100; CH_EN = 2'b11;
    tick();
    n_checks++;
    if ({A, nS, GNT, BUSY} !== {2'b10, 2'b11, 4'b0000, 1'b1})
      $display("FAIL single_settle got A=%b nS=%b GNT=%b BUSY=%b exp A=10 nS=11 GNT=0000 BUSY=1", A, nS, GNT, BUSY);
    else n_pass++;
    tick();
    n_checks++;
    if ({A, nS, GNT, BUSY} !== {2'b10, 2'b00, 4'b0100, 1'b1})
      $display("FAIL single_grant got A=%b nS=%b GNT=%b BUSY=%b exp A=10 nS=00 GNT=0100 BUSY=1", A, nS, GNT, BUSY);
    else n_pass++;
    REQ = 4'b0000;
    tick();
    n_checks++;
    if ({nS, GNT, BUSY} !== {2'b11, 4'b0000, 1'b0})
      $display("FAIL single_release got nS=%b GNT=%b BUSY=%b exp nS=11 GNT=0000 BUSY=0", nS, GNT, BUSY);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] prev_a;
    int owner, ph;
    do_reset();
    REQ = 4'b1111; CH_EN = 2'b10;
    prev_a = A;
    for (int t = 1; t <= 25; t++) begin
      tick();
      owner = ((t - 1) / 5) % 4;
      ph    = (t - 1) % 5;
      n_checks++;
      if (ph == 0) begin
        if ({A, nS, GNT, BUSY} !== {2'(owner), 2'b11, 4'b0000, 1'b1})
          $display("FAIL rr_settle t=%0d got A=%b nS=%b GNT=%b exp A=%0d nS=11 GNT=0000", t, A, nS, GNT, owner);
        else n_pass++;
      end else begin
        if ({A, nS, GNT, BUSY} !== {2'(owner), 2'b01, 4'b0001 << owner, 1'b1})
          $display("FAIL rr_grant t=%0d got A=%b nS=%b GNT=%b exp owner %0d nS=01", t, A, nS, GNT, owner);
        else n_pass++;
      end
      if (A !== prev_a) begin
        n_checks++;
        if (nS !== 2'b11) $display("FAIL rr_bbm t=%0d A changed with nS=%b exp 11", t, nS);
        else n_pass++;
      end
      prev_a = A;
    end
  endtask

  task automatic test_sole_preempt();
    int bad;
    do_reset();
    REQ = 4'b0001; CH_EN = 2'b11;
    tick();
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (GNT !== 4'b0001) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL sole_hold got %0d cycles without GNT=0001 exp 0", bad);
    else n_pass++;
    REQ = 4'b1001;
    tick();
    n_checks++;
    if ({A, nS, GNT, BUSY} !== {2'b11, 2'b11, 4'b0000, 1'b1})
      $display("FAIL preempt_settle got A=%b nS=%b GNT=%b BUSY=%b exp A=11 nS=11 GNT=0000 BUSY=1", A, nS, GNT, BUSY);
    else n_pass++;
    tick();
    n_checks++;
    if ({GNT, nS} !== {4'b1000, 2'b00})
      $display("FAIL preempt_grant got GNT=%b nS=%b exp GNT=1000 nS=00", GNT, nS);
    else n_pass++;
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    REQ = 4'b0010; CH_EN = 2'b11;
    tick();
    n_checks++;
    if ({A, nS, GNT, BUSY} !== {2'b01, 2'b11, 4'b0000, 1'b1})
      $display("FAIL abort_settle got A=%b nS=%b GNT=%b BUSY=%b exp A=01 nS=11 GNT=0000 BUSY=1", A, nS, GNT, BUSY);
    else n_pass++;
    REQ = 4'b0000;
    tick();
    n_checks++;
    if ({A, nS, GNT, BUSY} !== {2'b01, 2'b11, 4'b0000, 1'b0})
      $display("FAIL abort_idle got A=%b nS=%b GNT=%b BUSY=%b exp A=01 nS=11 GNT=0000 BUSY=0", A, nS, GNT, BUSY);
    else n_pass++;
    tick();
    n_checks++;
    if (GNT !== 4'b0000) $display("FAIL abort_nogrant got GNT=%b exp 0000", GNT);
    else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    REQ = 4'b0010; CH_EN = 2'b01;
    tick();
    tick();
    n_checks++;
    if ({nS, GNT} !== {2'b10, 4'b0010})
      $display("FAIL midrst_grant got nS=%b GNT=%b exp nS=10 GNT=0010", nS, GNT);
    else n_pass++;
    #2;
    RST = 1'b1;
    #1;
    n_checks++;
    if ({A, nS, GNT, BUSY} !== {2'b00, 2'b11, 4'b0000, 1'b0})
      $display("FAIL midrst_async got A=%b nS=%b GNT=%b BUSY=%b exp A=00 nS=11 GNT=0000 BUSY=0", A, nS, GNT, BUSY);
    else n_pass++;
    #1;
    RST = 1'b0;
    REQ = 4'b0101;
    tick();
    n_checks++;
    if ({A, BUSY} !== {2'b00, 1'b1}) $display("FAIL midrst_ptr got A=%b BUSY=%b exp A=00 BUSY=1", A, BUSY);
    else n_pass++;
    tick();
    n_checks++;
    if ({GNT, nS} !== {4'b0001, 2'b10}) $display("FAIL midrst_regrant got GNT=%b nS=%b exp GNT=0001 nS=10", GNT, nS);
    else n_pass++;
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] want;
    logic [1:0] prev_a;
    int bad_model, bad_oh, bad_bbm;
    do_reset();
    want = 4'b0000;
    bad_model = 0; bad_oh = 0; bad_bbm = 0;
    prev_a = A;
    for (int t = 0; t < 800; t++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) want[b] = ~want[b];
      end
      REQ = want;
      if ($urandom_range(0, 3) == 0) CH_EN = 2'($urandom);
      if (t == 400) begin
        #2; RST = 1'b1; #1; RST = 1'b0;
      end
      tick();
      if ({A, nS, GNT, BUSY} !== {exp_a, exp_ns, exp_gnt, exp_busy}) begin
        if (bad_model < 5)
          $display("FAIL rand_model t=%0d got A=%b nS=%b GNT=%b BUSY=%b exp A=%b nS=%b GNT=%b BUSY=%b",
                   t, A, nS, GNT, BUSY, exp_a, exp_ns, exp_gnt, exp_busy);
        bad_model++;
      end
      if (!$onehot0(GNT) || ((GNT != 4'b0000) && !BUSY)) bad_oh++;
      if ((A !== prev_a) && (nS !== 2'b11) && (t != 400)) bad_bbm++;
      prev_a = A;
    end
    n_checks++;
    if (bad_model != 0) $display("FAIL rand_model_total got %0d mismatching cycles exp 0", bad_model);
    else n_pass++;
    n_checks++;
    if (bad_oh != 0) $display("FAIL rand_onehot got %0d bad cycles exp 0", bad_oh);
    else n_pass++;
    n_checks++;
    if (bad_bbm != 0) $display("FAIL rand_bbm got %0d A changes with nS low exp 0", bad_bbm);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_sole_preempt();
    test_abort();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
